// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: ALU operation
// codes, base opcodes, controller state encoding, datapath mux selects and
// small decode helpers.
package rv_ctrl_pkg;

   // ALU operation codes (alu_control)
   localparam logic [4:0] AluAnd  = 5'd0;
   localparam logic [4:0] AluOr   = 5'd1;
   localparam logic [4:0] AluAdd  = 5'd2;
   localparam logic [4:0] AluSub  = 5'd3;
   localparam logic [4:0] AluSll  = 5'd4;
   localparam logic [4:0] AluSrl  = 5'd5;
   localparam logic [4:0] AluSra  = 5'd6;
   localparam logic [4:0] AluXor  = 5'd7;
   localparam logic [4:0] AluSlt  = 5'd9;
   localparam logic [4:0] AluSltu = 5'd10;

   // RV32I base opcodes (IR[6:0])
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcSystem = 7'b1110011;

   typedef enum logic [2:0] {
      StReset,
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StHalt
   } state_e;

   // pc_src
   localparam logic [1:0] PcSrcAlu    = 2'd0;
   localparam logic [1:0] PcSrcAluOut = 2'd1;
   localparam logic [1:0] PcSrcInit   = 2'd2;

   // alu_src_a
   localparam logic [1:0] SrcAPc   = 2'd0;
   localparam logic [1:0] SrcAReg  = 2'd1;
   localparam logic [1:0] SrcAZero = 2'd2;

   // alu_src_b
   localparam logic [1:0] SrcBReg  = 2'd0;
   localparam logic [1:0] SrcBFour = 2'd1;
   localparam logic [1:0] SrcBImm  = 2'd2;

   // wb_sel
   localparam logic [1:0] WbAluOut = 2'd0;
   localparam logic [1:0] WbMdr    = 2'd1;
   localparam logic [1:0] WbPc     = 2'd2;

   // OP / OP-IMM func3 to ALU op; alt selects SUB (000) or SRA (101).
   function automatic logic [4:0] alu_func3_op(input logic [2:0] f3, input logic alt);
      logic [4:0] op;
      unique case (f3)
         3'b000:  op = alt ? AluSub : AluAdd;
         3'b001:  op = AluSll;
         3'b010:  op = AluSlt;
         3'b011:  op = AluSltu;
         3'b100:  op = AluXor;
         3'b101:  op = alt ? AluSra : AluSrl;
         3'b110:  op = AluOr;
         default: op = AluAnd;
      endcase
      return op;
   endfunction

   // f3[2] picks the compare flag (zero vs. SLT/SLTU lsb), f3[0] inverts it.
   function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                         input logic lsb);
      return (f3[2] ? lsb : zero) ^ f3[0];
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/func3/func7 into the 5-bit ALU operation
// used in the execute step, plus a legality flag for the instruction.
// Ports:
//   opcode, func3, func7 : instruction fields from IR
//   alu_op               : ALU operation for the execute step (ADD for non-ALU ops)
//   legal                : 0 for unknown opcodes and illegal func3/func7 encodings
module alu_op_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   output logic [4:0] alu_op,
   output logic       legal
);

   always_comb begin
      alu_op = AluAdd;
      legal  = 1'b1;
      case (opcode)
         OpcOp: begin
            alu_op = alu_func3_op(func3, func7[5]);
            // func7 0x20 is only meaningful for SUB and SRA
            legal  = (func7 == 7'h00) ||
                     ((func7 == 7'h20) && ((func3 == 3'b000) || (func3 == 3'b101)));
         end
         OpcOpImm: begin
            // ADDI never becomes SUB; only SRAI uses func7[5]
            alu_op = alu_func3_op(func3, (func3 == 3'b101) && func7[5]);
         end
         OpcBranch: begin
            case (func3[2:1])
               2'b00:   alu_op = AluSub;
               2'b10:   alu_op = AluSlt;
               2'b11:   alu_op = AluSltu;
               default: legal  = 1'b0;
            endcase
         end
         OpcLoad, OpcStore, OpcJal, OpcJalr, OpcLui: begin
            alu_op = AluAdd;
         end
         OpcSystem: begin
            // SYSTEM is legal only as ECALL/EBREAK (func3 000)
            legal = (func3 == 3'b000);
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multi-cycle RV32I core. Steps the shared ALU
// through fetch, decode, execute, memory and write-back, and drives the
// unified memory port with a req/ack handshake.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   opcode, func3, func7        : IR fields
//   alu_zero, alu_lsb           : ALU result flags for branch resolution
//   mem_ack                     : memory completed the current request
//   mem_req, mem_we, iord       : memory request, write qualifier, address select
//   ir_we, mdr_we, pc_we        : datapath register enables
//   pc_src, pc_init             : PC source select and reset vector
//   alu_src_a, alu_src_b        : ALU operand selects
//   alu_control                 : ALU operation code
//   regwrite, wb_sel            : register file write enable and source select
//   halt, illegal               : core stopped (sticky), illegal opcode pulse
module multicycle_control
   import rv_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter bit          ILLEGAL_HALT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic        alu_zero,
   input  logic        alu_lsb,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_we,
   output logic        mdr_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic [31:0] pc_init,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [4:0]  alu_control,
   output logic        regwrite,
   output logic [1:0]  wb_sel,
   output logic        halt,
   output logic        illegal
);

   state_e     state_q, state_d;
   logic [4:0] dec_alu_op;
   logic       dec_legal;
   logic       is_load;
   logic       is_store;

   alu_op_decode u_alu_op_decode (
      .opcode (opcode),
      .func3  (func3),
      .func7  (func7),
      .alu_op (dec_alu_op),
      .legal  (dec_legal)
   );

   assign is_load  = (opcode == OpcLoad);
   assign is_store = (opcode == OpcStore);
   assign pc_init  = RESET_PC;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StReset;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_we       = 1'b0;
      mdr_we      = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PcSrcAlu;
      alu_src_a   = SrcAPc;
      alu_src_b   = SrcBReg;
      alu_control = AluAdd;
      regwrite    = 1'b0;
      wb_sel      = WbAluOut;
      halt        = 1'b0;
      illegal     = 1'b0;

      // While reset is held every output stays at its default, so a transfer
      // in flight is dropped and a coincident ack cannot fire any enable.
      if (rst_n) begin
         unique case (state_q)
            StReset: begin
               pc_we   = 1'b1;
               pc_src  = PcSrcInit;
               state_d = StFetch;
            end

            StFetch: begin
               mem_req   = 1'b1;
               alu_src_b = SrcBFour;
               if (mem_ack) begin
                  ir_we   = 1'b1;
                  pc_we   = 1'b1;
                  state_d = StDecode;
               end
            end

            StDecode: begin
               // PC+imm lands in ALUOut as the branch/JAL target
               alu_src_b = SrcBImm;
               if ((opcode == OpcSystem) && dec_legal) begin
                  state_d = StHalt;
               end else if (!dec_legal) begin
                  illegal = 1'b1;
                  state_d = ILLEGAL_HALT ? StHalt : StFetch;
               end else begin
                  state_d = StExec;
               end
            end

            StExec: begin
               alu_control = dec_alu_op;
               state_d     = StFetch;
               case (opcode)
                  OpcOp: begin
                     alu_src_a = SrcAReg;
                     state_d   = StWb;
                  end
                  OpcOpImm: begin
                     alu_src_a = SrcAReg;
                     alu_src_b = SrcBImm;
                     state_d   = StWb;
                  end
                  OpcLoad, OpcStore: begin
                     alu_src_a = SrcAReg;
                     alu_src_b = SrcBImm;
                     state_d   = StMem;
                  end
                  OpcBranch: begin
                     alu_src_a = SrcAReg;
                     if (branch_taken(func3, alu_zero, alu_lsb)) begin
                        pc_we  = 1'b1;
                        pc_src = PcSrcAluOut;
                     end
                  end
                  OpcJal: begin
                     // PC already holds PC+4, which is the link value
                     regwrite = 1'b1;
                     wb_sel   = WbPc;
                     pc_we    = 1'b1;
                     pc_src   = PcSrcAluOut;
                  end
                  OpcJalr: begin
                     alu_src_a = SrcAReg;
                     alu_src_b = SrcBImm;
                     regwrite  = 1'b1;
                     wb_sel    = WbPc;
                     pc_we     = 1'b1;
                     pc_src    = PcSrcAlu;
                  end
                  OpcLui: begin
                     alu_src_a = SrcAZero;
                     alu_src_b = SrcBImm;
                     state_d   = StWb;
                  end
                  default: begin
                     state_d = StFetch;
                  end
               endcase
            end

            StMem: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               mem_we  = is_store;
               if (mem_ack) begin
                  mdr_we  = is_load;
                  state_d = is_load ? StWb : StFetch;
               end
            end

            StWb: begin
               regwrite = 1'b1;
               wb_sel   = is_load ? WbMdr : WbAluOut;
               state_d  = StFetch;
            end

            StHalt: begin
               halt = 1'b1;
            end

            default: begin
               state_d = StReset;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instructions compared against an instruction-level expectation model.
module tb_multicycle_control;

   localparam logic [31:0] ResetPc = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic        alu_zero;
   logic        alu_lsb;
   logic        mem_ack;
   logic        mem_req;
   logic        mem_we;
   logic        iord;
   logic        ir_we;
   logic        mdr_we;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic [31:0] pc_init;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [4:0]  alu_control;
   logic        regwrite;
   logic [1:0]  wb_sel;
   logic        halt;
   logic        illegal;

   int n_checks = 0;
   int n_fail   = 0;

   // ALU code by func3 for OP/OP-IMM; the alternate form (SUB, SRA) is code+1
   logic [4:0] f3_op [8] = '{5'd2, 5'd4, 5'd9, 5'd10, 5'd7, 5'd5, 5'd1, 5'd0};

   always #5 clk = ~clk;

   multicycle_control #(
      .RESET_PC     (ResetPc),
      .ILLEGAL_HALT (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .func3       (func3),
      .func7       (func7),
      .alu_zero    (alu_zero),
      .alu_lsb     (alu_lsb),
      .mem_ack     (mem_ack),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .iord        (iord),
      .ir_we       (ir_we),
      .mdr_we      (mdr_we),
      .pc_we       (pc_we),
      .pc_src      (pc_src),
      .pc_init     (pc_init),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_control (alu_control),
      .regwrite    (regwrite),
      .wb_sel      (wb_sel),
      .halt        (halt),
      .illegal     (illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One reset edge; leaves the bench 1 ns after the edge that enters fetch.
   task automatic do_reset(input string name);
      rst_n   = 1'b0;
      mem_ack = 1'($urandom_range(0, 1));
      #3;
      check({name, ".rst_req"}, mem_req, 0);
      check({name, ".rst_halt"}, halt, 0);
      check({name, ".rst_illegal"}, illegal, 0);
      check({name, ".rst_alu"}, alu_control, 2);
      check({name, ".rst_en"}, {ir_we, mdr_we, regwrite, mem_we}, 0);
      tick();
      rst_n   = 1'b1;
      mem_ack = 1'b0;
      #3;
      check({name, ".reset_pc_we"}, pc_we, 1);
      check({name, ".reset_pc_src"}, pc_src, 2);
      check({name, ".reset_pc_init"}, pc_init, ResetPc);
      check({name, ".reset_req"}, mem_req, 0);
      check({name, ".reset_halt"}, halt, 0);
      tick();
   endtask

   // Runs one legal instruction from the fetch cycle to the next fetch and
   // compares an instruction-level summary of what the controller did.
   task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input int fwait, input int mwait,
                            input logic zero, input logic lsb);
      bit is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, taken, done;
      int cpi, e_post, e_a, e_b, e_rw, e_wb, e_pcw, e_pcsrc, e_mem, e_memwe;
      logic [4:0] e_alu;
      int n, mcnt, mem_cyc, we_cyc, mdr, rw, wb, pcw, pcs, ill, hlt, irw;
      int dec_a, dec_b, dec_alu, ex_a, ex_b, ex_alu;

      is_r    = (op == 7'h33);
      is_i    = (op == 7'h13);
      is_ld   = (op == 7'h03);
      is_st   = (op == 7'h23);
      is_br   = (op == 7'h63);
      is_jal  = (op == 7'h6F);
      is_jalr = (op == 7'h67);
      is_lui  = (op == 7'h37);

      case (f3)
         3'd0:       taken = zero;
         3'd1:       taken = !zero;
         3'd4, 3'd6: taken = lsb;
         default:    taken = !lsb;
      endcase

      if (is_r || is_i) begin
         e_alu = f3_op[f3];
         if (f7[5] && ((f3 == 3'd5) || (is_r && f3 == 3'd0))) e_alu = e_alu + 5'd1;
      end else if (is_br) begin
         e_alu = (f3 < 3'd4) ? 5'd3 : ((f3 < 3'd6) ? 5'd9 : 5'd10);
      end else begin
         e_alu = 5'd2;
      end

      cpi     = (is_br || is_jal || is_jalr) ? 3 : (is_ld ? 5 : 4);
      e_post  = cpi - 1 + ((is_ld || is_st) ? mwait : 0);
      e_a     = is_lui ? 2 : 1;
      e_b     = (is_r || is_br) ? 0 : 2;
      e_rw    = (is_st || is_br) ? 0 : 1;
      e_wb    = is_ld ? 1 : ((is_jal || is_jalr) ? 2 : 0);
      e_pcw   = (is_jal || is_jalr || (is_br && taken)) ? 1 : 0;
      e_pcsrc = is_jalr ? 0 : 1;
      e_mem   = (is_ld || is_st) ? mwait + 1 : 0;
      e_memwe = is_st ? mwait + 1 : 0;

      opcode   = op;
      func3    = f3;
      func7    = f7;
      alu_zero = zero;
      alu_lsb  = lsb;

      for (int w = 0; w <= fwait; w++) begin
         mem_ack = (w == fwait);
         #3;
         check({name, ".f_req"}, mem_req, 1);
         check({name, ".f_iord"}, iord, 0);
         check({name, ".f_we"}, mem_we, 0);
         check({name, ".f_ir_we"}, ir_we, mem_ack);
         check({name, ".f_pc_we"}, pc_we, mem_ack);
         if (w == fwait) begin
            check({name, ".f_pc_src"}, pc_src, 0);
            check({name, ".f_alu"}, {alu_src_a, alu_src_b, alu_control}, {2'd0, 2'd1, 5'd2});
         end
         tick();
      end

      n = 0; mcnt = 0; mem_cyc = 0; we_cyc = 0; mdr = 0; rw = 0; wb = -1; pcw = 0;
      pcs = -1; ill = 0; hlt = 0; irw = 0; done = 0;
      dec_a = -1; dec_b = -1; dec_alu = -1; ex_a = -1; ex_b = -1; ex_alu = -1;
      while (!done && n < 40) begin
         if (mem_req && !iord) begin
            done = 1;
         end else begin
            if (mem_req && iord) begin
               mem_ack = (mcnt == mwait);
               mcnt++;
            end else begin
               // acks without a request must be ignored
               mem_ack = 1'($urandom_range(0, 1));
            end
            #3;
            if (mem_req && iord) begin
               mem_cyc++;
               if (mem_we) we_cyc++;
            end
            if (n == 0) begin
               dec_a = alu_src_a; dec_b = alu_src_b; dec_alu = alu_control;
            end
            if (n == 1) begin
               ex_a = alu_src_a; ex_b = alu_src_b; ex_alu = alu_control;
            end
            if (regwrite) begin
               rw++;
               wb = wb_sel;
            end
            if (pc_we) begin
               pcw++;
               pcs = pc_src;
            end
            ill += int'(illegal);
            hlt += int'(halt);
            mdr += int'(mdr_we);
            irw += int'(ir_we);
            n++;
            tick();
         end
      end

      check({name, ".next_fetch"}, done, 1);
      check({name, ".cycles"}, n, e_post);
      check({name, ".dec_ops"}, {dec_a, dec_b, dec_alu}, {0, 2, 2});
      check({name, ".exec_alu"}, ex_alu, e_alu);
      if (!is_jal) check({name, ".exec_src"}, {ex_a, ex_b}, {e_a, e_b});
      check({name, ".regwrite"}, rw, e_rw);
      if (e_rw != 0) check({name, ".wb_sel"}, wb, e_wb);
      check({name, ".pc_we"}, pcw, e_pcw);
      if (e_pcw != 0) check({name, ".pc_src"}, pcs, e_pcsrc);
      check({name, ".mem_cycles"}, mem_cyc, e_mem);
      check({name, ".mem_we_cycles"}, we_cyc, e_memwe);
      check({name, ".mdr_we"}, mdr, is_ld ? 1 : 0);
      check({name, ".ir_we"}, irw, 0);
      check({name, ".illegal_halt"}, {ill, hlt}, {0, 0});
   endtask

   // Fetches an instruction that must stop the core; checks the illegal pulse.
   task automatic run_stop(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic exp_illegal);
      opcode  = op;
      func3   = f3;
      func7   = f7;
      mem_ack = 1'b1;
      #3;
      check({name, ".fetch_ir_we"}, ir_we, 1);
      tick();
      mem_ack = 1'b0;
      #3;
      check({name, ".illegal_pulse"}, illegal, exp_illegal);
      check({name, ".dec_req"}, mem_req, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         mem_ack = 1'($urandom_range(0, 1));
         #3;
         check({name, ".halt"}, halt, 1);
         check({name, ".halt_illegal"}, illegal, 0);
         check({name, ".halt_req"}, mem_req, 0);
         check({name, ".halt_en"}, {pc_we, ir_we, regwrite, mdr_we}, 0);
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [6:0] op, f7;
      logic [2:0] f3;
      int         cls;

      rst_n    = 1'b0;
      opcode   = 7'h00;
      func3    = 3'd0;
      func7    = 7'h00;
      alu_zero = 1'b0;
      alu_lsb  = 1'b0;
      mem_ack  = 1'b0;

      do_reset("init");

      // ADD x3,x1,x2 (0x002081B3), zero-wait memory
      run_instr("add", 7'h33, 3'd0, 7'h00, 0, 0, 1'b0, 1'b0);
      run_instr("sub", 7'h33, 3'd0, 7'h20, 0, 0, 1'b0, 1'b0);
      run_instr("srai", 7'h13, 3'd5, 7'h20, 0, 0, 1'b0, 1'b0);
      run_instr("addi_f7", 7'h13, 3'd0, 7'h20, 1, 0, 1'b0, 1'b0);
      run_instr("lw", 7'h03, 3'd2, 7'h00, 0, 3, 1'b0, 1'b0);
      run_instr("sw", 7'h23, 3'd2, 7'h00, 0, 2, 1'b0, 1'b0);
      run_instr("bne_tk", 7'h63, 3'd1, 7'h00, 0, 0, 1'b0, 1'b0);
      run_instr("bne_nt", 7'h63, 3'd1, 7'h00, 0, 0, 1'b1, 1'b0);
      run_instr("bgeu_tk", 7'h63, 3'd7, 7'h00, 0, 0, 1'b0, 1'b0);
      run_instr("jal", 7'h6F, 3'd0, 7'h00, 0, 0, 1'b0, 1'b0);
      run_instr("jalr", 7'h67, 3'd0, 7'h00, 2, 0, 1'b0, 1'b0);
      run_instr("lui", 7'h37, 3'd3, 7'h11, 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         cls = $urandom_range(0, 7);
         f3  = 3'($urandom);
         f7  = 7'($urandom);
         case (cls)
            0: begin
               op = 7'h33;
               f7 = ($urandom_range(0, 1) == 1 && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
            end
            1: op = 7'h13;
            2: op = 7'h03;
            3: op = 7'h23;
            4: begin
               op = 7'h63;
               if (f3[2:1] == 2'b01) f3[2] = 1'b1;
            end
            5: op = 7'h6F;
            6: op = 7'h67;
            default: op = 7'h37;
         endcase
         run_instr("rand", op, f3, f7, $urandom_range(0, 2), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      run_stop("opc7f", 7'h7F, 3'd0, 7'h00, 1'b1);
      do_reset("after_opc7f");
      run_stop("ecall", 7'h73, 3'd0, 7'h00, 1'b0);
      do_reset("after_ecall");
      run_stop("r_bad_f7", 7'h33, 3'd0, 7'h01, 1'b1);
      do_reset("after_bad_f7");
      run_stop("br_f3_010", 7'h63, 3'd2, 7'h00, 1'b1);
      do_reset("after_bad_br");

      // reset while a fetch is pending, with ack in the reset cycle
      mem_ack = 1'b0;
      #3;
      check("pend.req", mem_req, 1);
      tick();
      rst_n   = 1'b0;
      mem_ack = 1'b1;
      #3;
      check("pend.rst_req", mem_req, 0);
      check("pend.rst_en", {ir_we, pc_we, mdr_we, regwrite}, 0);
      tick();
      rst_n   = 1'b1;
      mem_ack = 1'b0;
      #3;
      check("pend.reset_req", mem_req, 0);
      check("pend.reset_pc", {pc_we, pc_src}, {1'b1, 2'd2});
      tick();
      run_instr("post_reset_add", 7'h33, 3'd0, 7'h00, 0, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main sequencing FSM for the multi-cycle RV32I core. One ALU is shared across fetch, address, execute and branch steps; this block steps it through those phases.
- Drives the unified memory port through a req/ack handshake.
- Decodes opcode/func3/func7 into per-state mux selects, register enables and the 5-bit ALU operation code.
- Sits between the datapath registers (PC, IR, A, B, ALUOut, MDR) and the register file.

Parameters:
RESET_PC, 32'h0000_0000, value driven on pc_init while in S_RESET
ILLEGAL_HALT, 1, 1 = enter S_HALT on an illegal opcode; 0 = treat the instruction as NOP

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  7  IR[6:0]
func3  in  3  IR[14:12]
func7  in  7  IR[31:25]
alu_zero  in  1  ALU result == 0
alu_lsb  in  1  ALU result bit 0 (SLT/SLTU outcome)
mem_ack  in  1  memory completed current request
mem_req  out  1  memory request, held until ack
mem_we  out  1  write qualifier for mem_req
iord  out  1  0 = address from PC, 1 = address from ALUOut
ir_we  out  1  load IR from mem rdata
mdr_we  out  1  load MDR from mem rdata
pc_we  out  1  PC write enable
pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = pc_init
pc_init  out  32  RESET_PC
alu_src_a  out  2  0 = PC, 1 = A, 2 = zero
alu_src_b  out  2  0 = B, 1 = const 4, 2 = immediate
alu_control  out  5  AND=0 OR=1 ADD=2 SUB=3 SLL=4 SRL=5 SRA=6 XOR=7 SLT=9 SLTU=10
regwrite  out  1  register file write enable
wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link)
halt  out  1  sticky: core stopped
illegal  out  1  one-cycle pulse on illegal opcode

Behaviour:
- Reset: while rst_n=0 at a clk edge, state <= S_RESET. Outputs during reset and in S_RESET: every enable and req is 0, alu_control=ADD, halt=0, illegal=0. In S_RESET only, pc_we=1 and pc_src=2.
- S_RESET -> S_FETCH.
- S_FETCH:
  - mem_req=1, iord=0, ALU = PC+4.
  - When mem_ack=1 in the same cycle: ir_we=1, pc_we=1, pc_src=0, -> S_DECODE.
  - Otherwise stay in S_FETCH with req held and all enables 0.
- S_DECODE:
  - ALU = PC+imm (a=0, b=2, ADD); result is latched into ALUOut as branch/JAL target.
  - Next state: S_EXEC for R/I/LOAD/STORE/BRANCH/JAL/JALR/LUI.
  - ECALL/EBREAK -> S_HALT.
  - Unknown opcode: pulse illegal, then -> S_HALT if ILLEGAL_HALT=1, else -> S_FETCH.
- S_EXEC:
  - R-type: a=1, b=0; op from func3, func7[5] selects SUB/SRA. Any other func7 is illegal.
  - I-ALU: a=1, b=2. func3=101 with func7[5]=1 gives SRA. func3=000 is always ADD; func7 is ignored.
  - LOAD/STORE: a=1, b=2, ADD.
  - BRANCH: a=1, b=0; op is SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
    - taken = BEQ:zero, BNE:!zero, BLT/BLTU:lsb, BGE/BGEU:!lsb.
    - If taken: pc_we=1, pc_src=1.
    - -> S_FETCH. func3 010/011 is illegal.
  - JAL: regwrite=1, wb_sel=2 (link = PC, already PC+4); pc_we=1, pc_src=1; -> S_FETCH.
  - JALR: a=1, b=2, ADD; regwrite=1, wb_sel=2; pc_we=1, pc_src=0 (LSB cleared in the datapath); -> S_FETCH.
  - LUI: a=2, b=2, ADD -> S_WB.
  - R/I -> S_WB. LOAD/STORE -> S_MEM.
- S_MEM:
  - mem_req=1, iord=1, mem_we = (STORE).
  - On ack: load sets mdr_we=1 -> S_WB; store -> S_FETCH.
  - Without ack: hold all outputs.
- S_WB: regwrite=1; wb_sel=1 for load, else 0; -> S_FETCH.
- S_HALT: absorbing state; halt=1; all enables 0. Left only by reset.
- Handshake rules:
  - mem_req, mem_we and iord stay stable from assertion until the ack cycle.
  - Ack arriving while req=0 is ignored.
  - Ack is never required to wait a minimum number of cycles; zero-wait ack completes in 1 cycle.
- Reset mid-transfer: req drops in the reset cycle. No enables fire even if ack arrives the same cycle.
- CPI with zero-wait memory: branch/JAL/JALR 3, R/I/LUI/store 4, load 5.

Decomposition:
- Package rv_ctrl_pkg holds:
  - ALU op codes (5-bit)
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, SYSTEM)
  - state enum
  - mux-select constants for pc_src, alu_src_a/b, wb_sel
- One sub-module, alu_op_decode: combinational opcode/func3/func7 to alu_control plus legality flag. The FSM stays in the top.

Test Plan:
- Reset then ADD (0x002081B3), ack same cycle as each req:
  - states RESET, FETCH, DECODE, EXEC (alu_control=2), WB (regwrite=1).
  - Next FETCH reached 4 cycles after the first FETCH.
- SUB (func7=0x20) and SRAI (func3=101, func7=0x20): alu_control=3 and 6 respectively in S_EXEC.
- LW with ack delayed 3 cycles in S_MEM:
  - mem_req=1, iord=1, mem_we=0 held 4 cycles.
  - Then mdr_we=1, then regwrite=1 with wb_sel=1.
- SW with ack delayed 2 cycles: mem_we=1 held 3 cycles, no regwrite, returns to S_FETCH.
- BNE (func3=001):
  - alu_zero=0 gives pc_we=1, pc_src=1.
  - alu_zero=1 gives pc_we=0.
  - Repeat BGEU with alu_lsb=0 gives taken.
- Opcode 7'h7F with ILLEGAL_HALT=1:
  - illegal pulses one cycle, halt=1 persists, mem_req stays 0.
  - rst_n=0 for one edge returns to S_RESET with halt=0.
  - Reset asserted during a pending fetch drops mem_req next cycle.
